// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Groups the byte-link handshake and the instruction-memory write port that
//   the program loader sits between.
//   master : the loader (consumes bytes, drives the memory write port)
//   slave  : the environment (byte source and memory write sink)
//   Signals:
//     rx_valid   byte on rx_data is valid this cycle
//     rx_data    incoming byte
//     rx_ready   loader accepts a byte this cycle
//     imem_we    single-cycle instruction-memory write strobe
//     imem_waddr word index being written
//     imem_wdata 16-bit instruction word
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [15:0]       imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Receives a framed byte stream (HDR, N, N x {hi, lo}, CHK), assembles
//   16-bit instruction words and writes them to instruction memory starting at
//   word 0. The core is held stalled until a complete frame whose CHK matches
//   the XOR of all payload bytes has been loaded.
//   Ports:
//     clock      system clock, rising edge
//     reset      asynchronous, active-high reset
//     bus        byte link + memory write port (master side)
//     cpu_hold   1 = core must stall / PC held at 0
//     load_done  program loaded and verified
//     load_error last frame rejected
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] HDR    = 8'hA5
) (
  input  logic          clock,
  input  logic          reset,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_error
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] widx_q;
  logic [7:0]        hi_q;
  logic [7:0]        chk_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wdata_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic       take;
  logic [7:0] chk_d;
  logic       last_word;
  logic       count_bad;

  // The loader never back-pressures the link.
  assign bus.rx_ready = 1'b1;
  assign take         = bus.rx_valid & bus.rx_ready;
  assign chk_d        = chk_q ^ bus.rx_data;
  // Word index is compared in 32 bits so N == DEPTH needs no extra index bit.
  assign last_word    = (32'(widx_q) + 32'd1) == 32'(cnt_q);
  assign count_bad    = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > 32'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      hi_q    <= '0;
      chk_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      we_q <= 1'b0;
      if (take) begin
        case (state_q)
          S_IDLE: begin
            if (bus.rx_data == HDR) state_q <= S_COUNT;
          end
          S_COUNT: begin
            if (count_bad) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              hold_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              cnt_q   <= bus.rx_data;
              widx_q  <= '0;
              chk_q   <= '0;
              state_q <= S_HI;
            end
          end
          S_HI: begin
            hi_q    <= bus.rx_data;
            chk_q   <= chk_d;
            state_q <= S_LO;
          end
          S_LO: begin
            chk_q   <= chk_d;
            we_q    <= 1'b1;
            waddr_q <= widx_q;
            wdata_q <= {hi_q, bus.rx_data};
            widx_q  <= widx_q + ADDR_W'(1);
            state_q <= last_word ? S_CHECK : S_HI;
          end
          S_CHECK: begin
            if (bus.rx_data == chk_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
              err_q   <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              hold_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          S_DONE: begin
            // A new header re-stalls the core before any word is overwritten.
            if (bus.rx_data == HDR) begin
              state_q <= S_COUNT;
              hold_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          S_ERROR: begin
            if (bus.rx_data == HDR) begin
              state_q <= S_COUNT;
              err_q   <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign load_done      = done_q;
  assign load_error     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int         ADDR_W = 8;
  localparam logic [7:0] HDR    = 8'hA5;

  logic clock;
  logic reset;
  logic cpu_hold, load_done, load_error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .HDR(HDR)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: frame bytes to send and the writes they must produce.
  logic [7:0]  fr_q[$];
  logic [23:0] exp_q[$];
  // Observed writes {addr, data} and write-strobe spacing monitor.
  logic [23:0] wr_q[$];
  int cyc         = 0;
  int last_we_cyc = -10;
  int merge_cnt   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      wr_q.push_back({bus.imem_waddr, bus.imem_wdata});
      if (cyc - last_we_cyc < 2) merge_cnt++;
      last_we_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int k;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        @(negedge clock);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end
    end
    @(negedge clock);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    k = 0;
    while (bus.rx_ready !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (k >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL rx_ready_timeout: rx_ready=%b required 1", bus.rx_ready);
    end
    @(posedge clock);
  endtask

  task automatic send_range(input int from, input int to, input bit rnd);
    for (int i = from; i <= to; i++) send_byte(fr_q[i], rnd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.rx_valid = 1'b0;
    end
  endtask

  // Builds a random frame of n words; bad corrupts the checksum byte.
  task automatic make_frame(input int n, input bit bad);
    logic [7:0]  chk;
    logic [15:0] w;
    fr_q.delete();
    exp_q.delete();
    fr_q.push_back(HDR);
    fr_q.push_back(8'(n));
    chk = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = ($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom);
      fr_q.push_back(w[15:8]);
      fr_q.push_back(w[7:0]);
      chk = chk ^ w[15:8] ^ w[7:0];
      exp_q.push_back({8'(i), w});
    end
    if (n > 0) fr_q.push_back(bad ? (chk ^ 8'($urandom_range(1, 255))) : chk);
  endtask

  task automatic test_reset;
    logic [29:0] act, req;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #1;
    act = {bus.rx_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata,
           cpu_hold, load_done, load_error};
    req = {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h", act, req);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Known two-word frame; CHK byte chosen by caller.
  task automatic test_basic(input logic [7:0] chk, input bit rnd, input string tag);
    logic [2:0] st;
    bit good;
    good = (chk == 8'h40);
    fr_q  = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, chk};
    exp_q = '{24'h00_1234, 24'h01_ABCD};
    wr_q.delete();
    merge_cnt = 0;
    send_range(0, 5, rnd);
    #1;
    st = {cpu_hold, load_done, load_error};
    n_checks++;
    if (st !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_status_before_chk: hold/done/err=%b required 100", tag, st);
    end
    send_range(6, 6, rnd);
    #1;
    st = {cpu_hold, load_done, load_error};
    n_checks++;
    if (st !== (good ? 3'b010 : 3'b101)) begin
      n_fail++;
      $display("FAIL %s_status_after_chk: hold/done/err=%b required %b", tag, st,
               good ? 3'b010 : 3'b101);
    end
    n_checks++;
    if (wr_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d required %0d", tag, wr_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_write_%0d: got %h required %h", tag, i,
                 (i < wr_q.size()) ? wr_q[i] : 24'hxxxxxx, exp_q[i]);
      end
    end
    n_checks++;
    if (merge_cnt != 0) begin
      n_fail++;
      $display("FAIL %s_we_spacing: %0d adjacent strobes required 0", tag, merge_cnt);
    end
    idle(1);
  endtask

  task automatic test_zero_count;
    logic [2:0] st;
    fr_q = '{8'h00, 8'hFF, 8'hA5, 8'h00};
    wr_q.delete();
    send_range(0, 3, 1'b0);
    #1;
    st = {cpu_hold, load_done, load_error};
    n_checks++;
    if (st !== 3'b101) begin
      n_fail++;
      $display("FAIL zero_count_error: hold/done/err=%b required 101", st);
    end
    send_byte(8'hA5, 1'b0);
    #1;
    n_checks++;
    if (load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count_hdr_clears: load_error=%b required 0", load_error);
    end
    fr_q = '{8'h01, 8'h00, 8'h01, 8'h01};
    send_range(0, 3, 1'b0);
    #1;
    st = {cpu_hold, load_done, load_error};
    n_checks++;
    if (st !== 3'b010) begin
      n_fail++;
      $display("FAIL zero_count_recover: hold/done/err=%b required 010", st);
    end
    n_checks++;
    if (wr_q.size() != 1 || wr_q[0] !== 24'h00_0001) begin
      n_fail++;
      $display("FAIL zero_count_writes: count %0d first %h required 1 x 000001",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 24'hxxxxxx);
    end
    idle(1);
  endtask

  task automatic test_restart;
    logic [2:0] st;
    send_byte(8'hA5, 1'b0);
    #1;
    st = {cpu_hold, load_done, load_error};
    n_checks++;
    if (st !== 3'b100) begin
      n_fail++;
      $display("FAIL restart_hold: hold/done/err=%b required 100", st);
    end
    wr_q.delete();
    fr_q = '{8'h01, 8'hFF, 8'hFF, 8'h00};
    send_range(0, 3, 1'b0);
    #1;
    st = {cpu_hold, load_done, load_error};
    n_checks++;
    if (st !== 3'b010) begin
      n_fail++;
      $display("FAIL restart_done: hold/done/err=%b required 010", st);
    end
    n_checks++;
    if (wr_q.size() != 1 || wr_q[0] !== 24'h00_FFFF) begin
      n_fail++;
      $display("FAIL restart_writes: count %0d first %h required 1 x 00FFFF",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 24'hxxxxxx);
    end
    idle(1);
  endtask

  task automatic test_async_reset;
    logic [29:0] act, req;
    logic [2:0]  st;
    fr_q = '{8'hA5, 8'h02, 8'h12};
    send_range(0, 2, 1'b0);
    @(negedge clock);
    bus.rx_valid = 1'b0;
    n_checks++;
    if ({bus.imem_waddr, bus.imem_wdata} !== 24'h01_ABCD) begin
      n_fail++;
      $display("FAIL async_reset_precond: waddr/wdata=%h required 01abcd",
               {bus.imem_waddr, bus.imem_wdata});
    end
    #2;
    reset = 1'b1;
    #1;
    act = {bus.rx_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata,
           cpu_hold, load_done, load_error};
    req = {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h required %h", act, req);
    end
    @(negedge clock);
    reset = 1'b0;
    wr_q.delete();
    fr_q = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
    send_range(0, 4, 1'b0);
    #1;
    st = {cpu_hold, load_done, load_error};
    n_checks++;
    if (st !== 3'b010 || wr_q.size() != 1 || wr_q[0] !== 24'h00_0007) begin
      n_fail++;
      $display("FAIL async_reset_reload: status %b writes %0d first %h required 010 1 000007",
               st, wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 24'hxxxxxx);
    end
    idle(1);
  endtask

  task automatic test_random_frames;
    logic [2:0] st, req;
    logic [7:0] g;
    int n;
    bit bad, rnd;
    for (int it = 0; it < 20; it++) begin
      n   = (it == 0) ? 255 : (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6));
      bad = ($urandom_range(0, 2) == 0);
      rnd = ($urandom_range(0, 1) == 1);
      make_frame(n, bad);
      wr_q.delete();
      merge_cnt = 0;
      // Stray non-header bytes between frames must be ignored.
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == HDR) g = 8'h00;
        send_byte(g, rnd);
      end
      send_range(0, fr_q.size() - 1, rnd);
      #1;
      st  = {cpu_hold, load_done, load_error};
      req = (n > 0 && !bad) ? 3'b010 : 3'b101;
      n_checks++;
      if (st !== req) begin
        n_fail++;
        $display("FAIL rand%0d_status: hold/done/err=%b required %b", it, st, req);
      end
      n_checks++;
      if (wr_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_write_count: got %0d required %0d", it, wr_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        if (i < wr_q.size() && wr_q[i] !== exp_q[i]) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand%0d_write_%0d: got %h required %h", it, i, wr_q[i], exp_q[i]);
        end else if (i < wr_q.size()) begin
          n_checks++;
        end
      end
      n_checks++;
      if (merge_cnt != 0) begin
        n_fail++;
        $display("FAIL rand%0d_we_spacing: %0d adjacent strobes required 0", it, merge_cnt);
      end
      idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_basic(8'h40, 1'b0, "good");
    test_basic(8'h41, 1'b0, "badchk");
    test_zero_count();
    test_basic(8'h40, 1'b0, "pre_restart");
    test_restart();
    test_basic(8'h40, 1'b0, "pre_reset");
    test_async_reset();
    test_basic(8'h40, 1'b1, "gapped");
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
